// File: rtl/fib_pkg.sv
// ---------------------------------------------------------------------------
// fib_pkg
// Shared definitions for the Fibonacci controller and its datapath.
//
// Contents:
//   FIB_BUS_WIDTH  default width of the index n and of the result
//   FIB_CONST0     value the datapath loads into its fib/reg2 registers
//   FIB_CONST1     value the datapath loads into its count/reg1 registers
//   fib_state_e    controller states IDLE, CLEAR, RUN, DONE
// ---------------------------------------------------------------------------
package fib_pkg;

  localparam int FIB_BUS_WIDTH = 8;

  localparam int FIB_CONST0 = 0;
  localparam int FIB_CONST1 = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } fib_state_e;

endpackage : fib_pkg

// File: rtl/fibonacci_ctrl.sv
// ---------------------------------------------------------------------------
// fibonacci_ctrl
// Sequencing FSM for the Fibonacci datapath. Accepts a start request with an
// index n, clears the datapath, lets it iterate until it raises Stop, then
// captures the datapath fib register and returns it with a one-cycle done.
//
// Configuration macro:
//   FIB_CTRL_TIMEOUT_EN  when defined, RUN is bounded to TIMEOUT_CYCLES cycles
//                        and an expired bound ends the operation with err=1.
//
// Parameters:
//   BUS_WIDTH       width of n and result (must match the datapath)
//   TIMEOUT_CYCLES  RUN cycle limit (present only with FIB_CTRL_TIMEOUT_EN)
//
// Ports:
//   clock, reset    clock and synchronous active-high reset
//   start, n_in     request and Fibonacci index (sampled only in IDLE)
//   busy            high from the accepted start through the DONE cycle
//   done            one-cycle pulse, result/err valid
//   result, err     captured datapath fib; err flags n==0 or timeout
//   dp_reset        datapath reset strobe (CLEAR)
//   dp_n            latched n driven to the datapath
//   dp_select       datapath mux select, 1 = constants, 0 = iterate
//   dp_en_reg1/2, dp_en_count, dp_en_n  datapath register enables
//   dp_stop         datapath Stop (count == regn)
//   dp_fib          datapath fibonacci register
// ---------------------------------------------------------------------------
module fibonacci_ctrl
  import fib_pkg::*;
#(
  parameter int BUS_WIDTH = FIB_BUS_WIDTH
`ifdef FIB_CTRL_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 512
`endif
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [BUS_WIDTH-1:0] n_in,
  output logic                 busy,
  output logic                 done,
  output logic [BUS_WIDTH-1:0] result,
  output logic                 err,
  output logic                 dp_reset,
  output logic [BUS_WIDTH-1:0] dp_n,
  output logic                 dp_select,
  output logic                 dp_en_reg1,
  output logic                 dp_en_reg2,
  output logic                 dp_en_count,
  output logic                 dp_en_n,
  input  logic                 dp_stop,
  input  logic [BUS_WIDTH-1:0] dp_fib
);

  fib_state_e state_q, state_d;
  logic [BUS_WIDTH-1:0] dpN_q, dpN_d;
  logic [BUS_WIDTH-1:0] result_q, result_d;
  logic err_q, err_d;
  logic timeout;

`ifdef FIB_CTRL_TIMEOUT_EN
  localparam int RunCntW = $clog2(TIMEOUT_CYCLES) + 1;

  logic [RunCntW-1:0] runCnt_q, runCnt_d;

  // RUN-cycle watchdog. It is cleared while in CLEAR so it starts from zero
  // on the first RUN cycle; timeout fires on the RUN cycle that completes the
  // TIMEOUT_CYCLES-th cycle spent waiting for Stop.
  always_comb begin
    runCnt_d = runCnt_q;
    timeout  = 1'b0;
    if (state_q == CLEAR) begin
      runCnt_d = '0;
    end else if (state_q == RUN) begin
      runCnt_d = runCnt_q + 1'b1;
      timeout  = (runCnt_q == RunCntW'(TIMEOUT_CYCLES - 1));
    end
  end

  // Watchdog counter register.
  always_ff @(posedge clock) begin
    if (reset) begin
      runCnt_q <= '0;
    end else begin
      runCnt_q <= runCnt_d;
    end
  end
`else
  // Without the watchdog, RUN waits for Stop indefinitely.
  assign timeout = 1'b0;
`endif

  // Next-state logic and the datapath-facing registers (latched n, captured
  // result, error flag). An n of zero is answered directly from IDLE without
  // touching the datapath, since the datapath cannot stop on count==0.
  always_comb begin
    state_d  = state_q;
    dpN_d    = dpN_q;
    result_d = result_q;
    err_d    = err_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (n_in != '0) begin
            dpN_d   = n_in;
            state_d = CLEAR;
          end else begin
            result_d = BUS_WIDTH'(FIB_CONST0);
            err_d    = 1'b1;
            state_d  = DONE;
          end
        end
      end

      CLEAR: begin
        state_d = RUN;
      end

      RUN: begin
        if (dp_stop) begin
          result_d = dp_fib;
          err_d    = 1'b0;
          state_d  = DONE;
        end else if (timeout) begin
          result_d = dp_fib;
          err_d    = 1'b1;
          state_d  = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and data registers. Reset abandons any operation in flight, so no
  // done pulse follows and the previously returned result is cleared.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      dpN_q    <= '0;
      result_q <= BUS_WIDTH'(FIB_CONST0);
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      dpN_q    <= dpN_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  // Moore strobes decoded from state only. CLEAR holds the datapath in reset
  // with the constant-select mux; RUN enables the iterating registers and the
  // datapath itself freezes once Stop is true. En_N is never needed because
  // the datapath loads regn from dp_n during its reset cycle.
  always_comb begin
    busy        = 1'b0;
    done        = 1'b0;
    dp_reset    = 1'b0;
    dp_select   = 1'b0;
    dp_en_reg1  = 1'b0;
    dp_en_reg2  = 1'b0;
    dp_en_count = 1'b0;
    dp_en_n     = 1'b0;

    unique case (state_q)
      IDLE: begin
      end
      CLEAR: begin
        busy      = 1'b1;
        dp_reset  = 1'b1;
        dp_select = 1'b1;
      end
      RUN: begin
        busy        = 1'b1;
        dp_en_reg1  = 1'b1;
        dp_en_reg2  = 1'b1;
        dp_en_count = 1'b1;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign result = result_q;
  assign err    = err_q;
  assign dp_n   = dpN_q;

endmodule : fibonacci_ctrl

// File: tb/tb_fibonacci_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fibonacci_ctrl
// Drives fibonacci_ctrl against a behavioural stand-in for the datapath and
// compares handshake timing, result and error against a reference model.
// Define FIB_CTRL_TIMEOUT_EN to also exercise the RUN watchdog.
// ---------------------------------------------------------------------------
module tb_fibonacci_ctrl;
  import fib_pkg::*;

  localparam int W = 8;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] n_in;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         err;
  logic         dp_reset;
  logic [W-1:0] dp_n;
  logic         dp_select;
  logic         dp_en_reg1;
  logic         dp_en_reg2;
  logic         dp_en_count;
  logic         dp_en_n;
  logic         dp_stop;
  logic [W-1:0] dp_fib;

  int checkCount = 0;
  int failCount  = 0;

  logic [W-1:0] fibTable [0:255];
  logic [W-1:0] lastDpN;
  bit           stuckStop = 1'b0;

  logic [W-1:0] stubRegn;
  logic [W-1:0] stubCount;
  int           stubSteps;

  fibonacci_ctrl #(
    .BUS_WIDTH(W)
`ifdef FIB_CTRL_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(16)
`endif
  ) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .n_in(n_in),
    .busy(busy),
    .done(done),
    .result(result),
    .err(err),
    .dp_reset(dp_reset),
    .dp_n(dp_n),
    .dp_select(dp_select),
    .dp_en_reg1(dp_en_reg1),
    .dp_en_reg2(dp_en_reg2),
    .dp_en_count(dp_en_count),
    .dp_en_n(dp_en_n),
    .dp_stop(dp_stop),
    .dp_fib(dp_fib)
  );

  always #5 clock = ~clock;

  // Datapath stand-in: reset loads regn and count=1; each enabled iterate
  // cycle advances one Fibonacci step until count reaches regn. The fib
  // register after k steps holds F(k-2) (zero for fewer than two steps).
  assign dp_stop = (stubCount == stubRegn) && !stuckStop;
  assign dp_fib  = (stubSteps < 2) ? '0 : fibTable[8'(stubSteps - 2)];

  always_ff @(posedge clock) begin
    if (dp_reset) begin
      stubRegn  <= dp_n;
      stubCount <= W'(FIB_CONST1);
      stubSteps <= 0;
    end else if (dp_en_reg1 && dp_en_reg2 && dp_en_count && !dp_select && !dp_stop) begin
      stubCount <= stubCount + 1'b1;
      stubSteps <= stubSteps + 1;
    end
  end

  // Expected result for index n: the datapath performs n-1 steps, so the
  // answer is F(n-3) mod 2^W, and zero for n below 3 (including the n==0 error).
  function automatic logic [W-1:0] refResult(input int n);
    logic [W-1:0] a, b, t;
    a = '0;
    b = 1;
    if (n < 3) return '0;
    for (int i = 0; i < n - 3; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  function automatic int refLatency(input int n);
    return (n == 0) ? 1 : n + 2;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // One complete request: start with n, optionally hammer start/n_in while
  // busy, wait (bounded) for done and check timing, strobes and data.
  task automatic applyStimulus(input logic [W-1:0] n, input bit noise,
                               input int expLat, input bit expErr,
                               input logic [W-1:0] expRes);
    int cycles, resets;
    bit sawDone, busyLow;
    logic [4:0] clearOut;
    logic [5:0] runOut;
    clearOut = '0;
    runOut   = '0;
    cycles   = 0;
    resets   = 0;
    sawDone  = 1'b0;
    busyLow  = 1'b0;
    if (n != 0) lastDpN = n;
    checkOutput("idleBeforeStart", busy, 0);
    start = 1'b1;
    n_in  = n;
    while (!sawDone && cycles < expLat + 24) begin
      @(negedge clock);
      cycles++;
      if (dp_reset) resets++;
      if (!busy) busyLow = 1'b1;
      if (done) sawDone = 1'b1;
      if (cycles == 1) clearOut = {dp_reset, dp_en_reg1, dp_en_reg2, dp_en_count, dp_en_n};
      if (cycles == 2) runOut = {dp_reset, dp_select, dp_en_reg1, dp_en_reg2, dp_en_count, dp_en_n};
      start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      n_in  = W'($urandom);
    end
    start = 1'b0;
    checkOutput("doneSeen", sawDone, 1);
    checkOutput("latency", cycles, expLat);
    checkOutput("result", result, expRes);
    checkOutput("err", err, expErr);
    checkOutput("busyHeld", busyLow, 0);
    checkOutput("dpResetCount", resets, (n != 0) ? 1 : 0);
    checkOutput("dpN", dp_n, lastDpN);
    if (n != 0) begin
      checkOutput("clearStrobes", clearOut, 5'b10000);
      if (expLat > 3) checkOutput("runStrobes", runOut, 6'b001110);
    end
    @(negedge clock);
    checkOutput("singleDone", done, 0);
    checkOutput("idleAfterDone", busy, 0);
    checkOutput("resultHeld", result, expRes);
  endtask

  initial begin
    logic [W-1:0] rn;
    fibTable[0] = W'(FIB_CONST0);
    fibTable[1] = W'(FIB_CONST1);
    for (int i = 2; i < 256; i++) fibTable[i] = fibTable[i-1] + fibTable[i-2];
    lastDpN = '0;
    reset = 1'b1;
    start = 1'b0;
    n_in  = '0;
    repeat (3) @(negedge clock);

    $display("[TB] reset state");
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstDone", done, 0);
    checkOutput("rstErr", err, 0);
    checkOutput("rstResult", result, 0);
    checkOutput("rstDpN", dp_n, 0);
    checkOutput("rstStrobes", {dp_reset, dp_select, dp_en_reg1, dp_en_reg2, dp_en_count, dp_en_n}, 0);
    reset = 1'b0;
    @(negedge clock);

    $display("[TB] directed requests");
    applyStimulus(8'd6, 1'b0, 8, 1'b0, 8'd2);
    applyStimulus(8'd8, 1'b0, 10, 1'b0, 8'd5);
    applyStimulus(8'd8, 1'b0, 10, 1'b0, 8'd5);
    applyStimulus(8'd1, 1'b0, 3, 1'b0, 8'd0);
    applyStimulus(8'd0, 1'b0, 1, 1'b1, 8'd0);
    applyStimulus(8'd2, 1'b0, 4, 1'b0, 8'd0);
    applyStimulus(8'd6, 1'b1, 8, 1'b0, 8'd2);
    applyStimulus(8'd255, 1'b0, refLatency(255), 1'b0, refResult(255));

    $display("[TB] reset during RUN");
    start = 1'b1;
    n_in  = 8'd6;
    repeat (4) begin
      @(negedge clock);
      start = 1'b1;
    end
    checkOutput("busyInRun3", busy, 1);
    reset = 1'b1;
    start = 1'b0;
    @(negedge clock);
    checkOutput("midRstBusy", busy, 0);
    checkOutput("midRstDone", done, 0);
    checkOutput("midRstResult", result, 0);
    reset = 1'b0;
    lastDpN = '0;
    @(negedge clock);
    checkOutput("postRstDone", done, 0);

    $display("[TB] random requests");
    for (int k = 0; k < 10; k++) begin
      rn = W'($urandom_range(0, 40));
      applyStimulus(rn, 1'($urandom_range(0, 1)), refLatency(int'(rn)), rn == 0, refResult(int'(rn)));
    end

`ifdef FIB_CTRL_TIMEOUT_EN
    // Stop never rises: done must follow 16 RUN cycles, returning the fib
    // value present after 15 datapath steps, i.e. the answer for n = 16.
    $display("[TB] watchdog");
    stuckStop = 1'b1;
    applyStimulus(8'd100, 1'b0, 1 + 16 + 1, 1'b1, refResult(16));
    stuckStop = 1'b0;
`endif

    $display("%0d/%0d checks passed", checkCount - failCount, checkCount);
    $finish;
  end

endmodule : tb_fibonacci_ctrl
